// File: rtl/dct_vec_rot_coeff_gen.sv
// Post-FFT rotation coefficient source for the forward DCT: one complex coefficient per bin,
// aligned with its sop/eop/index sideband, fixed two-clock latency from sink beat to source beat.

module dct_vec_rot_trig_rom #(
  parameter bit SIN_TABLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] addr,
  output logic [16:0] data
);

  // Q60 fixed point: pi, 1.0 and half of one Q16 output step.
  localparam logic signed [127:0] PI_Q60   = 128'sh3243F6A8885A308D;
  localparam logic signed [127:0] ONE_Q60  = 128'sh1000000000000000;
  localparam logic signed [127:0] HALF_Q60 = 128'sh80000000000;

  // round(65536 * trig(pi*a/4096)) via a Taylor series evaluated at elaboration time.
  function automatic logic [16:0] trig_q16(input logic [11:0] a, input bit want_sin);
    logic signed [127:0] x_v, x2_v, term_v, acc_v, den_v, res_v;
    x_v    = (PI_Q60 * $signed({116'd0, a})) >>> 12;
    x2_v   = (x_v * x_v) >>> 60;
    term_v = want_sin ? x_v : ONE_Q60;
    acc_v  = term_v;
    for (int n = 32'sd1; n <= 32'sd14; n++) begin
      den_v  = want_sin ? 128'(32'sd2 * n * (32'sd2 * n + 32'sd1))
                        : 128'(32'sd2 * n * (32'sd2 * n - 32'sd1));
      term_v = ((term_v * x2_v) >>> 60) / den_v;
      acc_v  = n[0] ? (acc_v - term_v) : (acc_v + term_v);
    end
    res_v = (acc_v + HALF_Q60) >>> 44;
    return 17'(res_v);
  endfunction

  logic [16:0] table_s [2048];

  for (genvar a = 0; a < 2048; a++) begin : g_tab
    localparam logic [16:0] VAL = trig_q16(12'(a), SIN_TABLE);
    assign table_s[a] = VAL;
  end

  // Synchronous read port: one clock from address to data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= 17'd0;
    end else begin
      data <= table_s[addr];
    end
  end

endmodule

module dct_vec_rot_coeff_gen #(
  parameter int wDataOut = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sink_valid,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic [11:0]                fftpts_in,
  output logic                       source_valid,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic [10:0]                source_idx,
  output logic signed [wDataOut-1:0] source_cos,
  output logic signed [wDataOut-1:0] source_sin,
  output logic                       frame_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [wDataOut-1:0] K0_COS = {{(wDataOut-17){1'b0}}, 17'd46341};

  // Returns {legal, shift} where shift = log2(2048/N).
  function automatic logic [3:0] decode_fftpts(input logic [11:0] pts);
    logic [3:0] res_v;
    case (pts)
      12'd2048: res_v = {1'b1, 3'd0};
      12'd1024: res_v = {1'b1, 3'd1};
      12'd512:  res_v = {1'b1, 3'd2};
      12'd256:  res_v = {1'b1, 3'd3};
      12'd128:  res_v = {1'b1, 3'd4};
      12'd64:   res_v = {1'b1, 3'd5};
      12'd32:   res_v = {1'b1, 3'd6};
      default:  res_v = {1'b0, 3'd0};
    endcase
    return res_v;
  endfunction

  state_t      state_r, state_s;
  logic [11:0] k_r, k_s;
  logic [2:0]  shift_r, shift_s;
  logic        legal_s;
  logic [2:0]  shift_dec_s;
  logic [11:0] last_s;
  logic        emit_s, emit_sop_s, emit_eop_s, err_s;
  logic [10:0] emit_idx_s, addr_s;
  logic        s1_valid_r, s1_sop_r, s1_eop_r, s1_err_r;
  logic [10:0] s1_idx_r;
  logic [16:0] rom_cos_s, rom_sin_s;

  assign {legal_s, shift_dec_s} = decode_fftpts(fftpts_in);
  assign last_s = (12'd2048 >> shift_r) - 12'd1;

  // Frame state, bin counter and latched size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      k_r     <= 12'd0;
      shift_r <= 3'd0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      shift_r <= shift_s;
    end
  end

  // Per-beat decision: emit, error, next frame position.
  always_comb begin
    state_s    = state_r;
    k_s        = k_r;
    shift_s    = shift_r;
    emit_s     = 1'b0;
    emit_sop_s = 1'b0;
    emit_eop_s = 1'b0;
    emit_idx_s = 11'd0;
    addr_s     = 11'd0;
    err_s      = 1'b0;
    if (sink_valid) begin
      if (sink_sop) begin
        // A sop always restarts; a running frame is abandoned and sop+eop can never be legal.
        err_s = (state_r == ST_RUN) | ~legal_s | sink_eop;
        if (legal_s) begin
          emit_s     = 1'b1;
          emit_sop_s = 1'b1;
          emit_eop_s = sink_eop;
          shift_s    = shift_dec_s;
          k_s        = sink_eop ? 12'd0 : 12'd1;
          state_s    = sink_eop ? ST_IDLE : ST_RUN;
        end else begin
          k_s     = 12'd0;
          state_s = ST_IDLE;
        end
      end else if (state_r == ST_RUN) begin
        if (k_r > last_s) begin
          err_s   = 1'b1;
          k_s     = 12'd0;
          state_s = ST_IDLE;
        end else begin
          emit_s     = 1'b1;
          emit_eop_s = sink_eop;
          emit_idx_s = k_r[10:0];
          addr_s     = k_r[10:0] << shift_r;
          if (sink_eop) begin
            err_s   = (k_r != last_s);
            k_s     = 12'd0;
            state_s = ST_IDLE;
          end else begin
            k_s     = k_r + 12'd1;
            state_s = ST_RUN;
          end
        end
      end else begin
        state_s = ST_IDLE;
      end
    end else begin
      state_s = state_r;
    end
  end

  dct_vec_rot_trig_rom #(.SIN_TABLE(1'b0)) rom_cos_idct_vec_rot (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_s),
    .data  (rom_cos_s)
  );

  dct_vec_rot_trig_rom #(.SIN_TABLE(1'b1)) rom_sin_idct_vec_rot (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_s),
    .data  (rom_sin_s)
  );

  // Stage 1: sideband travelling with the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sop_r   <= 1'b0;
      s1_eop_r   <= 1'b0;
      s1_idx_r   <= 11'd0;
      s1_err_r   <= 1'b0;
    end else begin
      s1_valid_r <= emit_s;
      s1_sop_r   <= emit_sop_s;
      s1_eop_r   <= emit_eop_s;
      s1_idx_r   <= emit_idx_s;
      s1_err_r   <= err_s;
    end
  end

  // Stage 2: output register with the DC-bin weight override.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_idx   <= 11'd0;
      source_cos   <= '0;
      source_sin   <= '0;
      frame_err    <= 1'b0;
    end else begin
      source_valid <= s1_valid_r;
      source_sop   <= s1_sop_r;
      source_eop   <= s1_eop_r;
      source_idx   <= s1_idx_r;
      frame_err    <= s1_err_r;
      if (!s1_valid_r) begin
        source_cos <= '0;
        source_sin <= '0;
      end else if (s1_idx_r == 11'd0) begin
        source_cos <= K0_COS;
        source_sin <= '0;
      end else begin
        source_cos <= {{(wDataOut-17){1'b0}}, rom_cos_s};
        source_sin <= -$signed({{(wDataOut-17){1'b0}}, rom_sin_s});
      end
    end
  end

endmodule

// File: tb/tb_dct_vec_rot_coeff_gen.sv
// Directed bench for dct_vec_rot_coeff_gen: beats driven on the falling edge, outputs of the beat
// driven two falling edges earlier checked on each falling edge against hand-computed values.

module tb_dct_vec_rot_coeff_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sink_valid, sink_sop, sink_eop;
  logic [11:0]        fftpts_in;
  logic               source_valid, source_sop, source_eop, frame_err;
  logic [10:0]        source_idx;
  logic signed [17:0] source_cos, source_sin;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit v, sop, eop, err, chk;
    int idx, cos, sin;
  } exp_t;

  exp_t pipe [2];
  exp_t none_e, e;

  always #5 clk = ~clk;

  dct_vec_rot_coeff_gen #(.wDataOut(18)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_idx   (source_idx),
    .source_cos   (source_cos),
    .source_sin   (source_sin),
    .frame_err    (frame_err)
  );

  function automatic exp_t ex(input bit v, input bit sop, input bit eop, input bit err, input int idx);
    exp_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.err = err; r.idx = idx;
    r.chk = 1'b0; r.cos = 0; r.sin = 0;
    return r;
  endfunction

  function automatic exp_t exc(input exp_t b, input int c, input int s);
    exp_t r;
    r = b; r.chk = 1'b1; r.cos = c; r.sin = s;
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t x);
    chk("valid", source_valid, x.v);
    chk("frame_err", frame_err, x.err);
    if (x.v) begin
      chk("sop", source_sop, x.sop);
      chk("eop", source_eop, x.eop);
      chk("idx", source_idx, x.idx);
      if (x.chk) begin
        chk("cos", source_cos, x.cos);
        chk("sin", source_sin, x.sin);
      end
    end
  endtask

  task automatic check_zero();
    chk("rst_valid", source_valid, 0);
    chk("rst_sop", source_sop, 0);
    chk("rst_eop", source_eop, 0);
    chk("rst_idx", source_idx, 0);
    chk("rst_cos", source_cos, 0);
    chk("rst_sin", source_sin, 0);
    chk("rst_err", frame_err, 0);
  endtask

  task automatic step(input bit v, input bit sop, input bit eop, input int pts, input exp_t x);
    @(negedge clk);
    check_out(pipe[1]);
    pipe[1] = pipe[0];
    pipe[0] = x;
    sink_valid = v;
    sink_sop   = sop;
    sink_eop   = eop;
    fftpts_in  = 12'(pts);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, none_e);
  endtask

  initial begin
    none_e = ex(1'b0, 1'b0, 1'b0, 1'b0, 0);
    pipe[0] = none_e;
    pipe[1] = none_e;
    rst_n = 1'b0;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; fftpts_in = 12'd0;
    repeat (2) @(negedge clk);
    check_zero();
    rst_n = 1'b1;
    idle(2);

    // N=32 contiguous; fftpts_in changes mid-frame and must be ignored
    e = exc(ex(1'b1, 1'b1, 1'b0, 1'b0, 0), 46341, 0);
    step(1'b1, 1'b1, 1'b0, 32, e);
    for (int k = 1; k < 32; k++) begin
      e = ex(1'b1, 1'b0, k == 31, 1'b0, k);
      if (k == 16) e = exc(e, 46341, -46341);
      step(1'b1, 1'b0, k == 31, 100, e);
    end
    idle(3);

    // N=2048 with alternating bubbles, full address range
    for (int i = 0; i < 4096; i++) begin
      if (i % 2 == 0) begin
        e = ex(1'b1, i == 0, i == 4094, 1'b0, i / 2);
        if (i / 2 == 1)    e = exc(e, 65536, -50);
        if (i / 2 == 1024) e = exc(e, 46341, -46341);
        if (i / 2 == 2047) e = exc(e, 50, -65536);
        step(1'b1, i == 0, i == 4094, 2048, e);
      end else begin
        step(1'b0, 1'b0, 1'b0, 2048, none_e);
      end
    end

    // N=64 then N=1024 back to back
    for (int k = 0; k < 64; k++) begin
      e = ex(1'b1, k == 0, k == 63, 1'b0, k);
      if (k == 1) e = exc(e, 65516, -1608);
      step(1'b1, k == 0, k == 63, 64, e);
    end
    for (int k = 0; k < 1024; k++) begin
      e = ex(1'b1, k == 0, k == 1023, 1'b0, k);
      if (k == 1) e = exc(e, 65536, -101);
      step(1'b1, k == 0, k == 1023, 1024, e);
    end
    idle(3);

    // illegal size: error pulse, whole frame silent
    step(1'b1, 1'b1, 1'b0, 100, ex(1'b0, 1'b0, 1'b0, 1'b1, 0));
    for (int k = 1; k < 10; k++) step(1'b1, 1'b0, k == 9, 32, none_e);
    idle(3);

    // N=128, early eop at k=50
    for (int k = 0; k <= 50; k++)
      step(1'b1, k == 0, k == 50, 128, ex(1'b1, k == 0, k == 50, k == 50, k));
    idle(2);

    // N=128, second sop at k=20 restarts the frame
    for (int k = 0; k < 20; k++)
      step(1'b1, k == 0, 1'b0, 128, ex(1'b1, k == 0, 1'b0, 1'b0, k));
    for (int k = 0; k < 128; k++)
      step(1'b1, k == 0, k == 127, 128, ex(1'b1, k == 0, k == 127, k == 0, k));
    idle(3);

    // N=32 overrun: beat 33 errors and is dropped, following eop ignored
    for (int k = 0; k < 32; k++)
      step(1'b1, k == 0, 1'b0, 32, ex(1'b1, k == 0, 1'b0, 1'b0, k));
    step(1'b1, 1'b0, 1'b0, 32, ex(1'b0, 1'b0, 1'b0, 1'b1, 0));
    step(1'b1, 1'b0, 1'b1, 32, none_e);
    idle(3);

    // sop and eop on the same beat
    step(1'b1, 1'b1, 1'b1, 32, exc(ex(1'b1, 1'b1, 1'b1, 1'b1, 0), 46341, 0));
    step(1'b1, 1'b0, 1'b0, 32, none_e);
    idle(3);

    // reset in the middle of an N=256 frame
    for (int k = 0; k <= 100; k++)
      step(1'b1, k == 0, 1'b0, 256, ex(1'b1, k == 0, 1'b0, 1'b0, k));
    #2 rst_n = 1'b0;
    #1 check_zero();
    pipe[0] = none_e;
    pipe[1] = none_e;
    step(1'b1, 1'b0, 1'b0, 256, none_e);
    step(1'b1, 1'b0, 1'b0, 256, none_e);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, k == 9, 256, none_e);
    for (int k = 0; k < 32; k++)
      step(1'b1, k == 0, k == 31, 32, ex(1'b1, k == 0, k == 31, 1'b0, k));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
